// File: rtl/assume_example_pkg.sv
// Shared constants and helpers for the a |-> ##[MIN_DLY:MAX_DLY] b checker.
package assume_example_pkg;

  localparam int DEFAULT_MIN_DLY = 1;
  localparam int DEFAULT_MAX_DLY = 3;
  localparam int MAX_DLY_LIMIT   = 16;

  // Bit k (1-based) is set when an attempt of age k may be satisfied by b.
  function automatic logic [MAX_DLY_LIMIT:1] window_mask(input int min_dly, input int max_dly);
    logic [MAX_DLY_LIMIT:1] m;
    m = {MAX_DLY_LIMIT{1'b0}};
    for (int k = 1; k <= MAX_DLY_LIMIT; k++) begin
      if ((k >= min_dly) && (k <= max_dly)) begin
        m[k] = 1'b1;
      end else begin
        m[k] = 1'b0;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/assume_example_window_tracker.sv
// Pending-attempt shift vector: bit k marks an unresolved attempt started k edges ago.
module assume_example_window_tracker
  import assume_example_pkg::*;
#(
  parameter int MIN_DLY = DEFAULT_MIN_DLY,
  parameter int MAX_DLY = DEFAULT_MAX_DLY
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  output logic hit,
  output logic expire,
  output logic any_pending
);

  localparam logic [MAX_DLY_LIMIT:1] WIN_FULL = window_mask(MIN_DLY, MAX_DLY);
  localparam logic [MAX_DLY:1]       WIN_MASK = WIN_FULL[MAX_DLY:1];
  // With a zero minimum delay, an attempt can pass on the very edge it starts.
  localparam logic                   ZERO_WIN = (MIN_DLY == 0) ? 1'b1 : 1'b0;

  logic [MAX_DLY:1] pend_r;
  logic [MAX_DLY:1] pend_next_s;
  logic             start_s;
  logic             hit_s;
  logic             expire_s;

  // Resolve in-window attempts, age the survivors and admit a new attempt.
  always_comb begin
    pend_next_s = {MAX_DLY{1'b0}};
    start_s     = a & ~(ZERO_WIN & b);
    hit_s       = b & ((|(pend_r & WIN_MASK)) | (ZERO_WIN & a));
    expire_s    = pend_r[MAX_DLY] & ~b;
    pend_next_s[1] = start_s;
    for (int k = 2; k <= MAX_DLY; k++) begin
      pend_next_s[k] = pend_r[k-1] & ~(b & WIN_MASK[k-1]);
    end
  end

  // Pending vector register; reset discards every outstanding attempt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r <= {MAX_DLY{1'b0}};
    end else begin
      pend_r <= pend_next_s;
    end
  end

  assign hit         = hit_s;
  assign expire      = expire_s;
  assign any_pending = |pend_next_s;

endmodule

// File: rtl/assume_example_checker.sv
// Synthesizable monitor for a |-> ##[MIN_DLY:MAX_DLY] b, disabled while rst is high.
module assume_example_checker
  import assume_example_pkg::*;
#(
  parameter int MIN_DLY = DEFAULT_MIN_DLY,
  parameter int MAX_DLY = DEFAULT_MAX_DLY
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  output logic assertion_pass,
  output logic assertion_fail,
  output logic assertion_active
);

  generate
    if ((MAX_DLY < 1) || (MAX_DLY > MAX_DLY_LIMIT)) begin : g_bad_max
      $error("assume_example_checker: MAX_DLY out of range 1..16");
    end
    if ((MIN_DLY < 0) || (MIN_DLY > MAX_DLY)) begin : g_bad_min
      $error("assume_example_checker: MIN_DLY must lie in 0..MAX_DLY");
    end
  endgenerate

  logic hit_s;
  logic expire_s;
  logic any_pending_s;

  assume_example_window_tracker #(
    .MIN_DLY (MIN_DLY),
    .MAX_DLY (MAX_DLY)
  ) u_tracker (
    .clk         (clk),
    .rst         (rst),
    .a           (a),
    .b           (b),
    .hit         (hit_s),
    .expire      (expire_s),
    .any_pending (any_pending_s)
  );

  // Register the per-edge verdicts; reset clears them immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      assertion_pass   <= 1'b0;
      assertion_fail   <= 1'b0;
      assertion_active <= 1'b0;
    end else begin
      assertion_pass   <= hit_s;
      assertion_fail   <= expire_s;
      assertion_active <= any_pending_s;
    end
  end

endmodule

// File: tb/tb_assume_example_checker.sv
// Randomized bench with an attempt-list reference model for two window settings.
module tb_assume_example_checker;

  localparam int MAXD = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a   = 1'b0;
  logic b   = 1'b0;
  logic pass0, fail0, act0;
  logic pass1, fail1, act1;

  int total = 0;
  int bad   = 0;
  int now   = 0;
  int q0[$];
  int q1[$];
  int qn[$];
  bit ep0, ef0, ea0, ep1, ef1, ea1;

  always #5 clk = ~clk;

  assume_example_checker #(.MIN_DLY(1), .MAX_DLY(MAXD)) dut0 (
    .clk(clk), .rst(rst), .a(a), .b(b),
    .assertion_pass(pass0), .assertion_fail(fail0), .assertion_active(act0)
  );

  assume_example_checker #(.MIN_DLY(0), .MAX_DLY(MAXD)) dut1 (
    .clk(clk), .rst(rst), .a(a), .b(b),
    .assertion_pass(pass1), .assertion_fail(fail1), .assertion_active(act1)
  );

  task automatic chk(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b at %0t", nm, act, exp, $time);
    end
  endtask

  // Attempts are kept as start-edge numbers; age is just now - start.
  task automatic model_step(input int min_dly, input int qi[$], input bit av, input bit bv,
                            input bit rv, input int t, output int qo[$],
                            output bit p, output bit f, output bit act);
    int age;
    qo = {};
    p = 1'b0; f = 1'b0; act = 1'b0;
    if (rv) return;
    foreach (qi[i]) begin
      age = t - qi[i];
      if (bv && age >= min_dly && age <= MAXD) p = 1'b1;
      else if (age >= MAXD) f = 1'b1;
      else qo.push_back(qi[i]);
    end
    if (av) begin
      if (min_dly == 0 && bv) p = 1'b1;
      else qo.push_back(t);
    end
    act = (qo.size() != 0);
  endtask

  // One clock: drive at negedge, update the model at posedge, compare just after.
  task automatic step(input bit na, input bit nb, input bit nr);
    @(negedge clk);
    a = na; b = nb; rst = nr;
    @(posedge clk);
    model_step(1, q0, na, nb, nr, now, qn, ep0, ef0, ea0); q0 = qn;
    model_step(0, q1, na, nb, nr, now, qn, ep1, ef1, ea1); q1 = qn;
    now++;
    #1;
    chk("pass0", pass0, ep0);  chk("fail0", fail0, ef0);  chk("active0", act0, ea0);
    chk("pass1", pass1, ep1);  chk("fail1", fail1, ef1);  chk("active1", act1, ea1);
  endtask

  initial begin
    // Reset with a and b high: nothing reported, nothing survives release.
    #1;
    chk("rst_pass", pass0, 1'b0); chk("rst_fail", fail0, 1'b0); chk("rst_active", act0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("rst_hold_active", act0, 1'b0); chk("rst_hold_pass1", pass1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("post_rst_active", act0, 1'b0); chk("post_rst_fail", fail0, 1'b0);

    // Pass at age 1.
    step(1'b1, 1'b0, 1'b0);
    chk("age1_active", act0, 1'b1); chk("age1_early_pass", pass0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("age1_pass", pass0, 1'b1); chk("age1_active_drop", act0, 1'b0); chk("age1_nofail", fail0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("age1_pulse_end", pass0, 1'b0);

    // Pass at age 3 (window edge).
    step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("age3_pass", pass0, 1'b1); chk("age3_nofail", fail0, 1'b0);

    // Late b at age 4 is too late and ignored.
    step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("late_fail", fail0, 1'b1); chk("late_active", act0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("late_b_nopass", pass0, 1'b0); chk("late_b_nofail", fail0, 1'b0);

    // Same-cycle b: outside window for MIN_DLY=1, immediate pass for MIN_DLY=0.
    step(1'b1, 1'b1, 1'b0);
    chk("age0_min0_pass", pass1, 1'b1); chk("age0_min0_idle", act1, 1'b0);
    chk("age0_min1_nopass", pass0, 1'b0);
    step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    chk("age0_min1_fail", fail0, 1'b1); chk("age0_min0_nofail", fail1, 1'b0);

    // Overlapping attempts all satisfied by one b.
    step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("ovl_pass", pass0, 1'b1); chk("ovl_active", act0, 1'b0); chk("ovl_nofail", fail0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("ovl_single_pulse", pass0, 1'b0);

    // Two overlapping attempts that both expire.
    step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("exp1_fail", fail0, 1'b1); chk("exp1_active", act0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("exp2_fail", fail0, 1'b1); chk("exp2_active", act0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("exp_done", fail0, 1'b0);

    // Reset mid-attempt: active drops asynchronously, attempt never reported.
    step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    chk("mid_active", act0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_async_active", act0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("mid_rst_nofail_a", fail0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("mid_rst_nofail_b", fail0, 1'b0); chk("mid_rst_nopass", pass0, 1'b0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(99) < 45), ($urandom_range(99) < 35), ($urandom_range(199) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
